// File: rtl/off_mem_pkg.sv
// Shared definitions for the off-chip-model BRAM arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package off_mem_pkg;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int ADDR_WIDTH_DEF = 8;

  // Requester identifiers, also used as the read-return tag id
  localparam logic REQ_R0 = 1'b0;
  localparam logic REQ_R1 = 1'b1;

  // Burst-lock state of the arbiter
  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } lock_state_t;

endpackage

// File: rtl/off_mem_arbiter_rr_arb2.sv
// Two-input round-robin grant with burst lock and external lock release.
// Latency: grant is combinational from req and registered pointer/lock state.
// Backpressure: a non-granted request is simply not granted; it must be held.
module rr_arb2
  import off_mem_pkg::*;
(
  input  logic clk,
  input  logic reset_n,
  input  logic req0,
  input  logic req1,
  input  logic lock0,
  input  logic lock1,
  input  logic timeout,
  output logic gnt0,
  output logic gnt1,
  output logic locked,
  output logic owner
);

  lock_state_t state, state_nxt;
  logic        owner_q, owner_nxt;
  logic        last_q, last_nxt;

  // Lock state, owner and last-granted pointer registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      owner_q <= REQ_R0;
      last_q  <= REQ_R1;
    end else begin
      state   <= state_nxt;
      owner_q <= owner_nxt;
      last_q  <= last_nxt;
    end
  end

  // Grant selection, pointer update and lock take/release
  always_comb begin
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    state_nxt = state;
    owner_nxt = owner_q;
    last_nxt  = last_q;

    if (state == LOCKED) begin
      // Only the owner may be granted; the other side keeps waiting
      gnt0 = req0 && (owner_q == REQ_R0);
      gnt1 = req1 && (owner_q == REQ_R1);
    end else if (req0 && req1) begin
      gnt0 = (last_q == REQ_R1);
      gnt1 = (last_q == REQ_R0);
    end else begin
      gnt0 = req0;
      gnt1 = req1;
    end

    if (gnt0 || gnt1) begin
      last_nxt = gnt1 ? REQ_R1 : REQ_R0;
      // A beat without lock releases in the cycle it is accepted; the
      // waiting side sees the release through the registered state only.
      if (gnt1 ? lock1 : lock0) begin
        state_nxt = LOCKED;
        owner_nxt = last_nxt;
      end else begin
        state_nxt = IDLE;
      end
    end else if (timeout) begin
      state_nxt = IDLE;
    end
  end

  assign locked = (state == LOCKED);
  assign owner  = owner_q;

endmodule

// File: rtl/off_mem_arbiter.sv
// Shares one BRAM (write port A, read port B) between two requesters, round-robin with burst lock.
// Latency: issue to BRAM in the grant cycle; read data/err returned exactly 1 cycle later.
// Backpressure: requesters hold req until gnt; the return path cannot be stalled.
module off_mem_arbiter
  import off_mem_pkg::*;
#(
  parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH   = ADDR_WIDTH_DEF,
  parameter int REQ_ADDR_W   = 32,
  parameter int LOCK_TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  r0_req,
  input  logic                  r0_we,
  input  logic [REQ_ADDR_W-1:0] r0_addr,
  input  logic [DATA_WIDTH-1:0] r0_wdata,
  input  logic                  r0_lock,
  output logic                  r0_gnt,
  output logic                  r0_rvalid,
  output logic [DATA_WIDTH-1:0] r0_rdata,
  output logic                  r0_err,
  input  logic                  r1_req,
  input  logic                  r1_we,
  input  logic [REQ_ADDR_W-1:0] r1_addr,
  input  logic [DATA_WIDTH-1:0] r1_wdata,
  input  logic                  r1_lock,
  output logic                  r1_gnt,
  output logic                  r1_rvalid,
  output logic [DATA_WIDTH-1:0] r1_rdata,
  output logic                  r1_err,
  output logic                  bram_wea,
  output logic [ADDR_WIDTH-1:0] bram_addra,
  output logic [DATA_WIDTH-1:0] bram_dina,
  output logic                  bram_enb,
  output logic [ADDR_WIDTH-1:0] bram_addrb,
  input  logic [DATA_WIDTH-1:0] bram_doutb
);

  localparam int CNT_W = $clog2(LOCK_TIMEOUT + 1);

  logic                  locked, owner, owner_req, idle, timeout;
  logic                  xfer, sel, sel_we, oor;
  logic [REQ_ADDR_W-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic [CNT_W-1:0]      cnt;
  logic                  rd_pend, rd_id, rd_oor;

  rr_arb2 u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .req0    (r0_req),
    .req1    (r1_req),
    .lock0   (r0_lock),
    .lock1   (r1_lock),
    .timeout (timeout),
    .gnt0    (r0_gnt),
    .gnt1    (r1_gnt),
    .locked  (locked),
    .owner   (owner)
  );

  // Issue mux: at most one grant, so the granted side owns both BRAM ports
  assign xfer      = r0_gnt | r1_gnt;
  assign sel       = r1_gnt ? REQ_R1 : REQ_R0;
  assign sel_we    = r1_gnt ? r1_we    : r0_we;
  assign sel_addr  = r1_gnt ? r1_addr  : r0_addr;
  assign sel_wdata = r1_gnt ? r1_wdata : r0_wdata;
  assign oor       = |sel_addr[REQ_ADDR_W-1:ADDR_WIDTH];

  // Out-of-range accesses are accepted but never reach the BRAM
  assign bram_wea   = xfer &  sel_we & ~oor;
  assign bram_enb   = xfer & ~sel_we & ~oor;
  assign bram_addra = sel_addr[ADDR_WIDTH-1:0];
  assign bram_addrb = sel_addr[ADDR_WIDTH-1:0];
  assign bram_dina  = sel_wdata;

  // Lock timeout: counts cycles the owner leaves its req low while locked
  assign owner_req = (owner == REQ_R1) ? r1_req : r0_req;
  assign idle      = locked & ~owner_req;
  assign timeout   = idle && (cnt == CNT_W'(LOCK_TIMEOUT - 1));

  // Idle counter; cleared on any owner transfer or when unlocked
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (!locked || xfer || timeout) begin
      cnt <= '0;
    end else if (idle) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Read-return tag and out-of-range error pulses
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_pend <= 1'b0;
      rd_id   <= REQ_R0;
      rd_oor  <= 1'b0;
      r0_err  <= 1'b0;
      r1_err  <= 1'b0;
    end else begin
      rd_pend <= xfer & ~sel_we;
      rd_id   <= sel;
      rd_oor  <= oor;
      r0_err  <= r0_gnt & oor;
      r1_err  <= r1_gnt & oor;
    end
  end

  assign r0_rvalid = rd_pend && (rd_id == REQ_R0);
  assign r1_rvalid = rd_pend && (rd_id == REQ_R1);
  assign r0_rdata  = (r0_rvalid && !rd_oor) ? bram_doutb : '0;
  assign r1_rdata  = (r1_rvalid && !rd_oor) ? bram_doutb : '0;

endmodule

// File: tb/tb_off_mem_arbiter.sv
// Self-checking bench for off_mem_arbiter: directed scenarios then random traffic vs a reference model.
// Latency: model expects returns/err one cycle after the accepting cycle.
// Backpressure: bench requesters hold req and fields until granted.
module tb_off_mem_arbiter;

  localparam int LT = 16;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        r0_req, r0_we, r0_lock, r1_req, r1_we, r1_lock;
  logic [31:0] r0_addr, r0_wdata, r1_addr, r1_wdata;
  logic        r0_gnt, r0_rvalid, r0_err, r1_gnt, r1_rvalid, r1_err;
  logic [31:0] r0_rdata, r1_rdata;
  logic        bram_wea, bram_enb;
  logic [7:0]  bram_addra, bram_addrb;
  logic [31:0] bram_dina, bram_doutb;

  off_mem_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .REQ_ADDR_W(32), .LOCK_TIMEOUT(LT)) dut (
    .clk(clk), .reset_n(reset_n),
    .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata), .r0_lock(r0_lock),
    .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata), .r0_err(r0_err),
    .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata), .r1_lock(r1_lock),
    .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata), .r1_err(r1_err),
    .bram_wea(bram_wea), .bram_addra(bram_addra), .bram_dina(bram_dina),
    .bram_enb(bram_enb), .bram_addrb(bram_addrb), .bram_doutb(bram_doutb)
  );

  always #5 clk = ~clk;

  // Simple BRAM: synchronous write on A, 1-cycle registered read on B
  logic [31:0] mem [256];
  always @(posedge clk) begin
    if (bram_wea) mem[bram_addra] <= bram_dina;
    if (bram_enb) bram_doutb <= mem[bram_addrb];
  end

  int n_checks = 0;
  int n_err    = 0;

  // Reference model state
  int          m_last, m_owner, m_idle, m_g;
  bit          exp_rv [2];
  bit          exp_err[2];
  logic [31:0] exp_rd;
  bit          exp_rd_known;
  logic [31:0] exp_mem   [256];
  bit          exp_known [256];
  logic        dut_g0, dut_g1;

  task automatic check1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_last = 1; m_owner = -1; m_idle = 0; m_g = -1;
    exp_rv = '{0, 0}; exp_err = '{0, 0};
  endtask

  task automatic drive(input int i, input bit q, input bit w, input logic [31:0] ad,
                       input logic [31:0] dt, input bit lk);
    if (i == 0) begin
      r0_req = q; r0_we = w; r0_addr = ad; r0_wdata = dt; r0_lock = lk;
    end else begin
      r1_req = q; r1_we = w; r1_addr = ad; r1_wdata = dt; r1_lock = lk;
    end
  endtask

  task automatic idle_all();
    drive(0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0);
  endtask

  // One clock cycle: check outputs against the model, then advance the model.
  // Entered and left at a falling edge with inputs already driven.
  task automatic cycle(input bit rst_here = 1'b0);
    int          g;
    bit          we, lk, oor, owner_req;
    logic [31:0] a, d;
    #1;
    check1("r0_rvalid", r0_rvalid, exp_rv[0]);
    check1("r1_rvalid", r1_rvalid, exp_rv[1]);
    if (exp_rv[0] && exp_rd_known) check32("r0_rdata", r0_rdata, exp_rd);
    if (exp_rv[1] && exp_rd_known) check32("r1_rdata", r1_rdata, exp_rd);
    check1("r0_err", r0_err, exp_err[0]);
    check1("r1_err", r1_err, exp_err[1]);

    owner_req = (m_owner == 1) ? r1_req : r0_req;
    if (m_owner >= 0)          g = owner_req ? m_owner : -1;
    else if (r0_req && r1_req) g = 1 - m_last;
    else if (r0_req)           g = 0;
    else if (r1_req)           g = 1;
    else                       g = -1;
    m_g = g;

    dut_g0 = r0_gnt;
    dut_g1 = r1_gnt;
    check1("gnt0", r0_gnt, g == 0);
    check1("gnt1", r1_gnt, g == 1);

    we  = (g == 1) ? r1_we    : r0_we;
    a   = (g == 1) ? r1_addr  : r0_addr;
    d   = (g == 1) ? r1_wdata : r0_wdata;
    lk  = (g == 1) ? r1_lock  : r0_lock;
    oor = (g >= 0) && (a >= 32'd256);
    check1("wea", bram_wea, (g >= 0) && we && !oor);
    check1("enb", bram_enb, (g >= 0) && !we && !oor);
    if (g >= 0 && !oor && we) begin
      check32("addra", {24'd0, bram_addra}, {24'd0, a[7:0]});
      check32("dina", bram_dina, d);
    end
    if (g >= 0 && !oor && !we) check32("addrb", {24'd0, bram_addrb}, {24'd0, a[7:0]});

    if (rst_here) begin
      #1 reset_n = 1'b0;
      model_reset();
    end else begin
      exp_rv = '{0, 0};
      exp_err = '{0, 0};
      if (g >= 0) begin
        exp_err[g] = oor;
        if (!we) begin
          exp_rv[g] = 1;
          if (oor) begin
            exp_rd = 32'd0; exp_rd_known = 1;
          end else begin
            exp_rd = exp_mem[a[7:0]]; exp_rd_known = exp_known[a[7:0]];
          end
        end else if (!oor) begin
          exp_mem[a[7:0]] = d; exp_known[a[7:0]] = 1;
        end
        m_owner = lk ? g : -1;
        m_idle  = 0;
        m_last  = g;
      end else if (m_owner >= 0) begin
        m_idle++;
        if (m_idle == LT) begin
          m_owner = -1; m_idle = 0;
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    idle_all();
    model_reset();
    #1;
    check1("rst_gnt0", r0_gnt, 1'b0);
    check1("rst_gnt1", r1_gnt, 1'b0);
    check1("rst_rvalid0", r0_rvalid, 1'b0);
    check1("rst_rvalid1", r1_rvalid, 1'b0);
    check1("rst_err0", r0_err, 1'b0);
    check1("rst_err1", r1_err, 1'b0);
    check32("rst_rdata0", r0_rdata, 32'd0);
    check32("rst_rdata1", r1_rdata, 32'd0);
    check1("rst_wea", bram_wea, 1'b0);
    check1("rst_enb", bram_enb, 1'b0);
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    int  lat;
    bit  pend [2];
    reset_n = 1'b0;
    idle_all();
    for (int i = 0; i < 256; i++) exp_known[i] = 0;
    model_reset();
    repeat (2) @(negedge clk);
    do_reset();

    // 1: write then read back through the other requester
    drive(0, 1, 1, 32'd5, 32'hDEADBEEF, 0);
    cycle();
    idle_all();
    drive(1, 1, 0, 32'd5, 32'd0, 0);
    cycle();
    idle_all();
    #1;
    check1("t1_r1_rvalid", r1_rvalid, 1'b1);
    check32("t1_rdata", r1_rdata, 32'hDEADBEEF);
    check1("t1_r0_rvalid", r0_rvalid, 1'b0);
    cycle();

    // 2: both read continuously, grants alternate starting with r0
    do_reset();
    drive(0, 1, 0, 32'd5, 32'd0, 0);
    drive(1, 1, 0, 32'd6, 32'd0, 0);
    for (int c = 0; c < 6; c++) begin
      cycle();
      check1("t2_alt", dut_g0, (c % 2) == 0);
    end
    idle_all();
    cycle();

    // 3: r0 locked burst of 4 writes holds off r1 until cycle 5
    do_reset();
    drive(1, 1, 0, 32'd5, 32'd0, 0);
    for (int c = 1; c <= 4; c++) begin
      drive(0, 1, 1, 32'd10 + c, 32'hA000_0000 + c, c < 4);
      cycle();
      check1("t3_r1_held", dut_g1, 1'b0);
    end
    drive(0, 0, 0, 0, 0, 0);
    cycle();
    check1("t3_r1_c5", dut_g1, 1'b1);
    idle_all();
    cycle();

    // 4: lock then go idle; r1 gets in exactly LT+1 cycles later
    drive(0, 1, 1, 32'd20, 32'h1234_5678, 1);
    drive(1, 1, 0, 32'd20, 32'd0, 0);
    cycle();
    check1("t4_r0_first", dut_g0, 1'b1);
    drive(0, 0, 0, 0, 0, 0);
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      cycle();
      if (dut_g1) begin
        lat = k;
        break;
      end
    end
    check32("t4_latency", lat, LT + 1);
    idle_all();
    cycle();

    // 5: out-of-range read and write
    drive(1, 1, 0, 32'h100, 32'd0, 0);
    #1;
    check1("t5_rd_gnt", r1_gnt, 1'b1);
    check1("t5_enb", bram_enb, 1'b0);
    cycle();
    drive(1, 1, 1, 32'h100, 32'h5555_AAAA, 0);
    #1;
    check1("t5_rd_err", r1_err, 1'b1);
    check1("t5_rd_rvalid", r1_rvalid, 1'b1);
    check32("t5_rd_rdata", r1_rdata, 32'd0);
    check1("t5_wea", bram_wea, 1'b0);
    cycle();
    idle_all();
    #1;
    check1("t5_wr_err", r1_err, 1'b1);
    check1("t5_wr_rvalid", r1_rvalid, 1'b0);
    cycle();

    // 6: reset hits the edge that would register a read
    drive(1, 1, 0, 32'd5, 32'd0, 0);
    cycle(1'b1);
    idle_all();
    #1;
    check1("t6_no_rvalid0", r0_rvalid, 1'b0);
    check1("t6_no_rvalid1", r1_rvalid, 1'b0);
    reset_n = 1'b1;
    drive(0, 1, 0, 32'd5, 32'd0, 0);
    drive(1, 1, 0, 32'd6, 32'd0, 0);
    cycle();
    check1("t6_r0_first", dut_g0, 1'b1);
    idle_all();
    cycle();
    cycle();

    // Fill a small window so random reads have known contents
    for (int i = 0; i < 16; i++) begin
      drive(1, 1, 1, i, $urandom, 0);
      cycle();
    end
    idle_all();

    // Random traffic with held requests, locks and out-of-range accesses
    pend = '{0, 0};
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 2; i++) begin
        if (pend[i] && m_g == i) pend[i] = 0;
        if (!pend[i]) begin
          if ($urandom_range(9) < 7) begin
            drive(i, 1, $urandom_range(1),
                  ($urandom_range(3) == 0) ? (32'h100 + $urandom_range(255)) : $urandom_range(15),
                  $urandom, $urandom_range(4) == 0);
            pend[i] = 1;
          end else begin
            drive(i, 0, 0, 0, 0, 0);
          end
        end
      end
      cycle();
    end
    idle_all();
    m_g = -1;
    cycle();
    cycle();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
